// File: rtl/pool2_maxpool.sv
// rtl/pool2_maxpool.sv - 2x2 stride-2 max pooling of a raster single-channel map
// Pairs pixels horizontally, keeps even-row maxima in a half-width line buffer, emits on odd/odd.
module pool2_maxpool #(
   parameter int DATAWIDTH_BUS = 8,
   parameter int IN_W          = 8,
   parameter int IN_H          = 8
) (
   input  logic                     Pool2_CLK,
   input  logic                     Pool2_RESETn,
   input  logic                     Pool2_Start,
   input  logic                     Pool2_InValid,
   input  logic [DATAWIDTH_BUS-1:0] Pool2_InBUS,
   output logic                     Pool2_Busy,
   output logic                     Pool2_OutValid,
   output logic [DATAWIDTH_BUS-1:0] Pool2_OutBUS,
   output logic                     Pool2_Done
);

   localparam int CW = $clog2(IN_W);
   localparam int RW = $clog2(IN_H);
   localparam int HW = (IN_W / 2 > 1) ? $clog2(IN_W / 2) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t                   state;
   logic [CW-1:0]            col;
   logic [RW-1:0]            row;
   logic [DATAWIDTH_BUS-1:0] pair;
   logic [DATAWIDTH_BUS-1:0] linebuf [IN_W/2];

   logic [HW-1:0]            lb_idx;
   logic [DATAWIDTH_BUS-1:0] lb_rd;
   logic [DATAWIDTH_BUS-1:0] hmax;
   logic [DATAWIDTH_BUS-1:0] vmax;
   logic                     last_col;
   logic                     last_row;

   assign lb_idx   = HW'(col >> 1);
   assign lb_rd    = linebuf[lb_idx];
   assign hmax     = (pair > Pool2_InBUS) ? pair : Pool2_InBUS;
   assign vmax     = (hmax > lb_rd) ? hmax : lb_rd;
   assign last_col = (col == CW'(IN_W - 1));
   assign last_row = (row == RW'(IN_H - 1));

   always_ff @(posedge Pool2_CLK or negedge Pool2_RESETn) begin
      if (!Pool2_RESETn) begin
         state          <= S_IDLE;
         col            <= '0;
         row            <= '0;
         pair           <= '0;
         Pool2_Busy     <= 1'b0;
         Pool2_OutValid <= 1'b0;
         Pool2_OutBUS   <= '0;
         Pool2_Done     <= 1'b0;
         for (int i = 0; i < IN_W / 2; i++) begin
            linebuf[i] <= '0;
         end
      end else begin
         Pool2_OutValid <= 1'b0;
         Pool2_Done     <= 1'b0;
         case (state)
            S_IDLE: begin
               if (Pool2_Start) begin
                  state      <= S_RUN;
                  col        <= '0;
                  row        <= '0;
                  Pool2_Busy <= 1'b1;
               end
            end
            S_RUN: begin
               if (Pool2_InValid) begin
                  if (!col[0]) begin
                     pair <= Pool2_InBUS;
                  end else if (!row[0]) begin
                     linebuf[lb_idx] <= hmax;
                  end else begin
                     Pool2_OutBUS   <= vmax;
                     Pool2_OutValid <= 1'b1;
                  end
                  if (last_col) begin
                     col <= '0;
                     row <= last_row ? '0 : row + RW'(1);
                  end else begin
                     col <= col + CW'(1);
                  end
                  // Done is registered so it lands with the final OutValid strobe
                  if (last_col && last_row) begin
                     state      <= S_DONE;
                     Pool2_Done <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               state      <= S_IDLE;
               Pool2_Busy <= 1'b0;
            end
            default: begin
               state      <= S_IDLE;
               Pool2_Busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pool2_maxpool.sv
// tb/tb_pool2_maxpool.sv - directed bench for pool2_maxpool (8x8 and 4x2 instances)
module tb_pool2_maxpool;

   logic       clk;
   logic       rst_n;
   logic       start8, inv8, start4, inv4;
   logic [7:0] in8, in4;
   logic       busy8, ov8, done8, busy4, ov4, done4;
   logic [7:0] ob8, ob4;

   int n_tests = 0;
   int n_fail  = 0;
   int cnt8 = 0, dcnt8 = 0, cnt4 = 0, dcnt4 = 0;

   pool2_maxpool #(.DATAWIDTH_BUS(8), .IN_W(8), .IN_H(8)) u_dut8 (
      .Pool2_CLK     (clk),
      .Pool2_RESETn  (rst_n),
      .Pool2_Start   (start8),
      .Pool2_InValid (inv8),
      .Pool2_InBUS   (in8),
      .Pool2_Busy    (busy8),
      .Pool2_OutValid(ov8),
      .Pool2_OutBUS  (ob8),
      .Pool2_Done    (done8)
   );

   pool2_maxpool #(.DATAWIDTH_BUS(8), .IN_W(4), .IN_H(2)) u_dut4 (
      .Pool2_CLK     (clk),
      .Pool2_RESETn  (rst_n),
      .Pool2_Start   (start4),
      .Pool2_InValid (inv4),
      .Pool2_InBUS   (in4),
      .Pool2_Busy    (busy4),
      .Pool2_OutValid(ov4),
      .Pool2_OutBUS  (ob4),
      .Pool2_Done    (done4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (ov8)   cnt8++;
      if (done8) dcnt8++;
      if (ov4)   cnt4++;
      if (done4) dcnt4++;
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] max2(input logic [7:0] a, input logic [7:0] b);
      return (a > b) ? a : b;
   endfunction

   // Drive one pixel, then check what the DUT shows in the following cycle.
   task automatic px(input bit sel, input logic [7:0] v, input int r, input int c,
                     input logic [7:0] exp_v);
      int w, h;
      bit odd, last;
      w = sel ? 4 : 8;
      h = sel ? 2 : 8;
      odd  = (r % 2 == 1) && (c % 2 == 1);
      last = (r == h - 1) && (c == w - 1);
      if (sel) begin inv4 = 1'b1; in4 = v; end
      else     begin inv8 = 1'b1; in8 = v; end
      @(posedge clk);
      #1;
      inv4 = 1'b0;
      inv8 = 1'b0;
      @(negedge clk);
      check("out_valid", sel ? ov4 : ov8, odd);
      if (odd) check("out_bus", sel ? ob4 : ob8, exp_v);
      check("done", sel ? done4 : done8, last);
   endtask

   task automatic idle8();
      @(posedge clk);
      @(negedge clk);
      check("stall_out_valid", ov8, 0);
      check("stall_done", done8, 0);
   endtask

   task automatic frame8(input int pat, input int gap);
      logic [7:0] img [8][8];
      logic [7:0] ev;
      int base_o, base_d;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            img[r][c] = (pat == 0) ? 8'(r * 8 + c) : 8'h00;
      if (pat == 1) begin
         img[2][4] = 8'h80; img[2][5] = 8'h7F;
         img[3][4] = 8'h01; img[3][5] = 8'hFE;
      end
      base_o = cnt8;
      base_d = dcnt8;
      start8 = 1'b1;
      @(posedge clk);
      #1 start8 = 1'b0;
      @(negedge clk);
      check("busy_after_start", busy8, 1);
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            ev = 8'h00;
            if ((r % 2 == 1) && (c % 2 == 1))
               ev = max2(max2(img[r-1][c-1], img[r-1][c]), max2(img[r][c-1], img[r][c]));
            if (pat == 1 && r == 3 && c == 5) check("unsigned_window", ev, 8'hFE);
            px(1'b0, img[r][c], r, c, ev);
            if (!(r == 7 && c == 7))
               for (int g = 0; g < gap; g++) idle8();
         end
      end
      check("busy_in_done", busy8, 1);
      @(posedge clk);
      @(negedge clk);
      check("busy_after_done", busy8, 0);
      check("done_after_done", done8, 0);
      check("out_count8", cnt8 - base_o, 16);
      check("done_count8", dcnt8 - base_d, 1);
   endtask

   task automatic frame4(input logic [63:0] pix, input logic [7:0] e0, input logic [7:0] e1);
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 4; c++)
            px(1'b1, pix[8 * (r * 4 + c) +: 8], r, c, (c == 1) ? e0 : e1);
   endtask

   initial begin
      int base_o, base_d;
      rst_n = 1'b0;
      start8 = 1'b0; inv8 = 1'b0; in8 = 8'h00;
      start4 = 1'b0; inv4 = 1'b0; in4 = 8'h00;

      // Reset, then IDLE must ignore input pixels
      repeat (3) @(negedge clk);
      check("rst_busy", busy8, 0);
      check("rst_out_valid", ov8, 0);
      check("rst_out_bus", ob8, 0);
      check("rst_done", done8, 0);
      rst_n = 1'b1;
      inv8 = 1'b1; in8 = 8'hFF;
      repeat (4) begin
         @(negedge clk);
         check("idle_out_valid", ov8, 0);
         check("idle_busy", busy8, 0);
      end
      inv8 = 1'b0;
      check("idle_out_count", cnt8, 0);

      frame8(0, 0);
      frame8(1, 0);
      frame8(0, 2);

      // Mid-frame reset abandons the frame
      base_o = cnt8;
      base_d = dcnt8;
      start8 = 1'b1;
      @(posedge clk);
      #1 start8 = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 20; i++)
         px(1'b0, 8'(i), i / 8, i % 8, 8'(((i / 8) * 8 + (i % 8))));
      base_o = cnt8;
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      inv8 = 1'b1; in8 = 8'hFF;
      repeat (6) @(negedge clk);
      inv8 = 1'b0;
      check("abort_busy", busy8, 0);
      check("abort_out_count", cnt8 - base_o, 0);
      check("abort_done_count", dcnt8 - base_d, 0);
      frame8(0, 0);

      // Back-to-back 4x2 frames; Start in the DONE cycle must be ignored
      start4 = 1'b1;
      @(posedge clk);
      #1 start4 = 1'b0;
      @(negedge clk);
      check("busy4_start", busy4, 1);
      frame4(64'h0807060504030201, 8'd6, 8'd8);
      check("busy4_in_done", busy4, 1);
      start4 = 1'b1;
      @(posedge clk);
      #1 start4 = 1'b0;
      @(negedge clk);
      check("start_in_done_ignored", busy4, 0);
      start4 = 1'b1;
      @(posedge clk);
      #1 start4 = 1'b0;
      @(negedge clk);
      check("busy4_restart", busy4, 1);
      frame4(64'h0000000009000009, 8'd9, 8'd9);
      @(posedge clk);
      @(negedge clk);
      check("busy4_end", busy4, 0);
      check("out_count4", cnt4, 4);
      check("done_count4", dcnt4, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pool2_maxpool.md
Name: pool2_maxpool

Overview:
- Second 2x2/stride-2 max-pooling stage. Sits directly upstream of the fully-connected layer and produces the 8-bit values that layer reads on its input bus.
- Consumes a raster-ordered single-channel feature map of IN_W x IN_H unsigned post-ReLU pixels, one pixel per valid cycle.
- Emits (IN_W/2) x (IN_H/2) pooled values in raster order, then pulses Pool2_Done so the FC stage can be enabled.

Parameters:
- DATAWIDTH_BUS, 8, pixel width in and out (unsigned).
- IN_W, 8, input feature-map width; even, >= 2.
- IN_H, 8, input feature-map height; even, >= 2.

Ports:
- Pool2_CLK  input  1  single system clock, rising edge.
- Pool2_RESETn  input  1  asynchronous active-low reset.
- Pool2_Start  input  1  one-cycle pulse that begins a frame.
- Pool2_InValid  input  1  Pool2_InBUS carries a pixel this cycle.
- Pool2_InBUS  input  DATAWIDTH_BUS  input pixel, unsigned.
- Pool2_Busy  output  1  high from accepted Start until Done.
- Pool2_OutValid  output  1  one-cycle strobe; Pool2_OutBUS holds a pooled value.
- Pool2_OutBUS  output  DATAWIDTH_BUS  pooled maximum, feeds FC_InBUS.
- Pool2_Done  output  1  one-cycle pulse after the last pooled value.

Behaviour:
- Reset (asynchronous, Pool2_RESETn=0):
  - State goes to IDLE.
  - Outputs reset to Busy=0, OutValid=0, OutBUS=0, Done=0.
  - Column and row counters and the line buffer are cleared to 0.
  - Reset asserted mid-frame abandons the frame. No Done is issued.
- State machine IDLE -> RUN -> DONE -> IDLE:
  - IDLE: Pool2_InValid is ignored. On Pool2_Start=1, go to RUN next cycle, clear col/row, and set Busy=1.
  - RUN: each cycle with InValid=1 consumes one pixel. Cycles with InValid=0 stall with no state change, and gaps of any length are allowed. Start is ignored in RUN.
  - RUN -> DONE on the cycle that consumes pixel (col=IN_W-1, row=IN_H-1).
  - DONE: lasts exactly one cycle. Done=1 there; this is the same cycle OutValid presents the last pooled value. Busy falls to 0 on the next cycle, which is IDLE.
  - Start in the DONE cycle is ignored.
- Counters:
  - col runs 0..IN_W-1 and wraps to 0 with row+1.
  - row runs 0..IN_H-1.
  - Both advance only on consumed pixels.
- Datapath:
  - A horizontal pair register holds the pixel at even col.
  - At odd col, hmax = max(pair, pixel).
  - Even row: hmax is written to line buffer entry col>>1. The buffer is IN_W/2 entries of DATAWIDTH_BUS.
  - Odd row: the result is max(hmax, linebuf[col>>1]).
  - All comparisons are unsigned. No saturation is needed because the output width equals the input width.
- Output timing:
  - OutBUS and OutValid are registered.
  - Latency is exactly 1 cycle: the pixel (odd col, odd row) consumed at edge N gives OutValid=1 and the result on OutBUS during cycle N+1.
  - OutValid is 0 all other cycles. OutBUS holds its last value when OutValid=0.
- Output count: exactly (IN_W/2)*(IN_H/2) OutValid pulses per frame. For the defaults that is 16.
- No backpressure: the downstream stage must accept every OutValid strobe.
- Equal pixels: the max is that value. A tie requires no special handling.

Test Plan:
- Reset then idle: hold RESETn=0 for 3 cycles, then release. All outputs stay 0. Driving InValid=1 with InBUS=0xFF in IDLE gives no OutValid and Busy=0.
- Ramp frame (8x8 defaults): pixel value = row*8+col, continuous InValid. Expect 16 outputs in order 9,11,13,15,25,27,...,63. Each output arrives 1 cycle after its odd/odd pixel. Done pulses together with value 63, then Busy=0.
- Unsigned max: one window of {0x80, 0x7F, 0x01, 0xFE}, all other pixels 0. That window outputs 0xFE, not 0x7F.
- Stalled input: same ramp frame with InValid toggling 1,0,0,1,... Identical output sequence and values. Done comes only after the 64th consumed pixel.
- Mid-frame reset: pulse RESETn low after 20 pixels. No further OutValid and no Done. A new Start plus a full ramp frame gives the correct 16 outputs, with no residue from the line buffer.
- Back-to-back frames, IN_W=4, IN_H=2:
  - Frame 1 = {1,2,3,4 / 5,6,7,8} gives outputs 6, 8.
  - Start pulsed in the DONE cycle is ignored.
  - Start one cycle later, with frame {9,0,0,9 / 0,0,0,0}, gives outputs 9, 9.
